// File: rtl/bram_arbiter_pkg.sv
// bram_arbiter_pkg: shared state encoding, byte-enable and port-id constants for the BRAM arbiter
package bram_arbiter_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int LANES = 4;

    localparam logic [LANES-1:0] BE_FULL = 4'b1111;
    localparam logic [LANES-1:0] BE_NONE = 4'b0000;

    localparam logic PORT_LSU = 1'b0;
    localparam logic PORT_LOADER = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_WR     = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4
    } state_t;

    // Access state entered on grant; a store with no lanes enabled never touches memory.
    function automatic state_t access_state(input logic we, input logic [LANES-1:0] be);
        return !we ? ST_RD : (be == BE_FULL) ? ST_WR : (be == BE_NONE) ? ST_IDLE : ST_RMW_RD;
    endfunction

endpackage

// File: rtl/bram_lane_merge.sv
// bram_lane_merge: per-byte select between old and new words under byte enables
module bram_lane_merge
    import bram_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_WIDTH
) (
    input  logic [DATA_W-1:0] i_old,
    input  logic [DATA_W-1:0] i_new,
    input  logic [LANES-1:0]  i_be,
    output logic [DATA_W-1:0] o_merged
);

    localparam int LW = DATA_W / LANES;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign o_merged[i*LW +: LW] = i_be[i] ? i_new[i*LW +: LW] : i_old[i*LW +: LW];
    end

endmodule

// File: rtl/bram_arbiter.sv
// bram_arbiter: round-robin two-port sequencer for bram32 with read-modify-write partial stores
module bram_arbiter
    import bram_arbiter_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [LANES-1:0]  be0,
    input  logic [LANES-1:0]  be1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-3:0] mem_w_addr,
    output logic [DATA_W-1:0] mem_w_dat,
    output logic              mem_w_enb,
    output logic [ADDR_W-3:0] mem_r_addr,
    output logic              mem_r_enb,
    input  logic [DATA_W-1:0] mem_r_dat
);

    state_t            r_state;
    logic              r_we;
    logic [ADDR_W-3:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [LANES-1:0]  r_be;
    logic              r_id;
    logic              r_rr_last;
    logic [1:0]        r_done;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_merge;

    state_t            w_next;
    logic              w_gnt;
    logic              w_pick;
    logic              w_we;
    logic [ADDR_W-3:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [LANES-1:0]  w_be;
    logic              w_done_set;
    logic              w_done_id;
    logic [DATA_W-1:0] w_merged;
    logic              w_unused;

    assign w_unused = ^{addr0[1:0], addr1[1:0]};

    bram_lane_merge #(.DATA_W(DATA_W)) u_merge (
        .i_old    (r_merge),
        .i_new    (r_wdata),
        .i_be     (r_be),
        .o_merged (w_merged)
    );

    // Arbitration: a lone requester wins, contention goes to the port not granted last.
    always_comb begin
        w_pick  = (req0 && req1) ? ~r_rr_last : (req1 ? PORT_LOADER : PORT_LSU);
        w_gnt   = (r_state == ST_IDLE) && !rst && (req0 || req1);
        w_we    = w_pick ? we1 : we0;
        w_addr  = w_pick ? addr1[ADDR_W-1:2] : addr0[ADDR_W-1:2];
        w_wdata = w_pick ? wdata1 : wdata0;
        w_be    = w_pick ? be1 : be0;
    end

    // Next state and which port completes at the coming edge.
    always_comb begin
        w_next     = r_state;
        w_done_set = 1'b0;
        w_done_id  = r_id;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt) begin
                    w_next     = access_state(w_we, w_be);
                    w_done_set = w_we && (w_be == BE_NONE);
                    w_done_id  = w_pick;
                end
            end
            ST_RD, ST_WR, ST_RMW_WR: begin
                w_next     = ST_IDLE;
                w_done_set = 1'b1;
            end
            ST_RMW_RD: w_next = ST_RMW_WR;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Memory port drive; enables are forced low while reset is asserted so an aborted RMW never writes.
    always_comb begin
        mem_r_enb  = !rst && (r_state == ST_RD || r_state == ST_RMW_RD);
        mem_w_enb  = !rst && (r_state == ST_WR || r_state == ST_RMW_WR);
        mem_r_addr = r_addr;
        mem_w_addr = r_addr;
        mem_w_dat  = (r_state == ST_RMW_WR) ? w_merged : r_wdata;
    end

    assign gnt0  = w_gnt && (w_pick == PORT_LSU);
    assign gnt1  = w_gnt && (w_pick == PORT_LOADER);
    assign done0 = r_done[0];
    assign done1 = r_done[1];
    assign rdata = r_rdata;
    assign busy  = (r_state != ST_IDLE);

    // State, request latch, round-robin pointer and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_id      <= PORT_LSU;
            r_rr_last <= PORT_LOADER;
            r_done    <= 2'b00;
            r_rdata   <= '0;
            r_merge   <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= w_done_set ? (w_done_id ? 2'b10 : 2'b01) : 2'b00;
            if (w_gnt) begin
                r_we      <= w_we;
                r_addr    <= w_addr;
                r_wdata   <= w_wdata;
                r_be      <= w_be;
                r_id      <= w_pick;
                r_rr_last <= w_pick;
            end
            if (r_state == ST_RD) r_rdata <= mem_r_dat;
            if (r_state == ST_RMW_RD) r_merge <= mem_r_dat;
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: table-driven, contention, reset-abort and random checks against a word-level memory model
module tb_bram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  we = 2'b00;
    logic [11:0] ad [2];
    logic [31:0] wd [2];
    logic [3:0]  bs [2];

    logic        gnt0, gnt1, done0, done1, busy, mem_w_enb, mem_r_enb;
    logic [31:0] rdata, mem_w_dat, mem_r_dat;
    logic [9:0]  mem_w_addr, mem_r_addr;

    logic [31:0] bmem [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] last_rd = 32'h0;
    logic        last_g = 1'b1;
    int          cyc = 0;
    int          wr_cnt = 0;
    logic        both_seen = 1'b0;
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        logic        p;
        logic        we;
        logic [11:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;
    vec_t tbl [11];

    bram_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
        .addr0(ad[0]), .addr1(ad[1]), .wdata0(wd[0]), .wdata1(wd[1]),
        .be0(bs[0]), .be1(bs[1]),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .busy(busy),
        .mem_w_addr(mem_w_addr), .mem_w_dat(mem_w_dat), .mem_w_enb(mem_w_enb),
        .mem_r_addr(mem_r_addr), .mem_r_enb(mem_r_enb), .mem_r_dat(mem_r_dat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 1024; i++) bmem[i] <= 32'h0;
        end else if (mem_w_enb) begin
            bmem[mem_w_addr] <= mem_w_dat;
        end
    end

    always @(posedge clk) if (mem_w_enb) wr_cnt <= wr_cnt + 1;

    always @(negedge clk) if (mem_r_enb && mem_w_enb) both_seen <= 1'b1;

    assign mem_r_dat = mem_r_enb ? bmem[mem_r_addr] : 32'hBAD0BAD0;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (n & m) | (o & ~m);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic access(input logic p, input logic w, input logic [11:0] a, input logic [31:0] d,
                          input logic [3:0] be, output logic [31:0] rd, output int lat);
        int g;
        int n;
        lat = -1;
        rd = 32'hx;
        @(posedge clk); #1;
        we[p] = w; ad[p] = a; wd[p] = d; bs[p] = be; req[p] = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (p ? gnt1 : gnt0) break;
            if (++n > 50) begin
                fails++; tests++;
                $display("FAIL grant timeout port %0d", p);
                req[p] = 1'b0;
                return;
            end
        end
        g = cyc;
        last_g = p;
        @(posedge clk); #1;
        req[p] = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            if (p ? done1 : done0) break;
            if (++n > 50) begin
                fails++; tests++;
                $display("FAIL done timeout port %0d", p);
                return;
            end
        end
        lat = cyc - g;
        rd = rdata;
    endtask

    task automatic do_op(input string name, input logic p, input logic w, input logic [11:0] a,
                         input logic [31:0] d, input logic [3:0] be, input logic [31:0] exp_rd, input int exp_lat);
        logic [31:0] rd;
        int lat;
        int w0;
        w0 = wr_cnt;
        access(p, w, a, d, be, rd, lat);
        check({name, " rdata"}, rd, exp_rd);
        check({name, " latency"}, lat, exp_lat);
        check({name, " writes"}, wr_cnt - w0, (w && be != 4'b0) ? 1 : 0);
        if (w) ref_mem[a[11:2]] = merge(ref_mem[a[11:2]], d, be);
        else last_rd = exp_rd;
    endtask

    task automatic contend(input logic [11:0] b0, input logic [11:0] b1);
        int k [2];
        logic exp_next;
        logic gp;
        logic gflag;
        logic dp;
        int nd;
        logic q_port [$];
        logic [31:0] q_dat [$];
        k = '{0, 0};
        nd = 0;
        gflag = 1'b0;
        gp = 1'b0;
        exp_next = ~last_g;
        @(posedge clk); #1;
        we = 2'b00; ad[0] = b0; ad[1] = b1; req = 2'b11;
        for (int c = 0; c < 200 && nd < 8; c++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                gp = gnt1;
                check("contend grant order", {31'b0, gp}, {31'b0, exp_next});
                exp_next = ~gp;
                last_g = gp;
                q_port.push_back(gp);
                q_dat.push_back(ref_mem[ad[gp][11:2]]);
                gflag = 1'b1;
            end
            if (done0 || done1) begin
                dp = done1;
                if (q_port.size() == 0) begin
                    check("contend spurious done", {31'b0, dp}, 32'hFFFFFFFF);
                end else begin
                    check("contend done port", {31'b0, dp}, {31'b0, q_port[0]});
                    check("contend rdata", rdata, q_dat[0]);
                    last_rd = q_dat[0];
                    void'(q_port.pop_front());
                    void'(q_dat.pop_front());
                end
                nd++;
            end
            @(posedge clk); #1;
            if (gflag) begin
                k[gp]++;
                if (k[gp] == 4) req[gp] = 1'b0;
                else ad[gp] = ad[gp] + 12'd4;
                gflag = 1'b0;
            end
        end
        req = 2'b00;
        check("contend completions", nd, 8);
    endtask

    initial begin
        logic [11:0] a;
        logic [3:0] be;
        logic w;
        logic p;
        logic [31:0] d;
        logic sawd;
        int w0;
        int mism;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        for (int i = 0; i < 2; i++) begin
            ad[i] = 12'h0; wd[i] = 32'h0; bs[i] = 4'h0;
        end

        tbl[0]  = '{1'b0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 32'h00000000, 2};
        tbl[1]  = '{1'b0, 1'b0, 12'h010, 32'h0,        4'hF, 32'hDEADBEEF, 2};
        tbl[2]  = '{1'b0, 1'b1, 12'h020, 32'h11223344, 4'hF, 32'hDEADBEEF, 2};
        tbl[3]  = '{1'b0, 1'b1, 12'h020, 32'h00AA0000, 4'h4, 32'hDEADBEEF, 3};
        tbl[4]  = '{1'b1, 1'b0, 12'h020, 32'h0,        4'h0, 32'h11AA3344, 2};
        tbl[5]  = '{1'b1, 1'b1, 12'h020, 32'hFFFFFFFF, 4'h0, 32'h11AA3344, 1};
        tbl[6]  = '{1'b0, 1'b0, 12'h020, 32'h0,        4'h0, 32'h11AA3344, 2};
        tbl[7]  = '{1'b1, 1'b1, 12'h3FC, 32'hCAFEF00D, 4'h3, 32'h11AA3344, 3};
        tbl[8]  = '{1'b1, 1'b0, 12'h3FF, 32'h0,        4'h0, 32'h0000F00D, 2};
        tbl[9]  = '{1'b0, 1'b1, 12'h021, 32'h000000EE, 4'h1, 32'h0000F00D, 3};
        tbl[10] = '{1'b0, 1'b0, 12'h020, 32'h0,        4'h0, 32'h11AA33EE, 2};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset outputs", {25'b0, gnt0, gnt1, done0, done1, busy, mem_r_enb, mem_w_enb}, 32'h0);
        check("reset rdata", rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        clr = 1'b0;

        contend(12'h100, 12'h200);

        for (int i = 0; i < 11; i++)
            do_op($sformatf("vec%0d", i), tbl[i].p, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].be,
                  tbl[i].exp_rd, tbl[i].exp_lat);

        contend(12'h010, 12'h020);

        @(posedge clk); #1;
        we[0] = 1'b1; ad[0] = 12'h020; wd[0] = 32'h0000BB00; bs[0] = 4'b0010; req[0] = 1'b1;
        @(negedge clk);
        check("rmw abort grant", {31'b0, gnt0}, 32'h1);
        @(posedge clk); #1;
        req[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        w0 = wr_cnt;
        @(negedge clk);
        check("rmw abort no write enable", {31'b0, mem_w_enb}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_rd = 32'h0;
        last_g = 1'b1;
        sawd = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done0 || done1) sawd = 1'b1;
        end
        check("rmw abort no done", {31'b0, sawd}, 32'h0);
        check("rmw abort idle", {31'b0, busy}, 32'h0);
        check("rmw abort writes", wr_cnt - w0, 0);
        check("rmw abort word", bmem[8], 32'h11AA33EE);
        check("rmw abort rdata reset", rdata, 32'h0);

        for (int i = 0; i < 40; i++) begin
            p = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = {2'b01, 6'($urandom_range(0, 7)), 2'b00, 2'($urandom_range(0, 3))};
            d = $urandom;
            case ($urandom_range(0, 3))
                0: be = 4'h0;
                1: be = 4'hF;
                default: be = 4'($urandom_range(0, 15));
            endcase
            do_op($sformatf("rand%0d", i), p, w, a, d, be, w ? last_rd : ref_mem[a[11:2]],
                  !w ? 2 : (be == 4'hF) ? 2 : (be == 4'h0) ? 1 : 3);
        end

        contend(12'h400, 12'h410);

        @(posedge clk); #1;
        mism = 0;
        for (int i = 0; i < 1024; i++) if (bmem[i] !== ref_mem[i]) mism++;
        check("memory image", mism, 0);
        check("read/write enable overlap", {31'b0, both_seen}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
